// File: rtl/dh_encrypt_modexp_pkg.sv
// Shared types and timing helpers for the modular-exponentiation encryption stage.
// Holds the FSM state enum, modmul cycle count and the start-to-done latency formula.
package dh_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REDUCE,
    S_SQR,
    S_MUL,
    S_FIN
  } dh_enc_state_t;

  // One load cycle precedes the W shift-add iterations of every modmul.
  localparam int DH_MM_LOAD_CYCLES = 1;

  function automatic int dh_mm_cycles(input int w);
    return w + DH_MM_LOAD_CYCLES;
  endfunction

  function automatic int dh_latency(input int w, input int ew, input int pop);
    return 3 + (1 + ew + pop) * dh_mm_cycles(w);
  endfunction

endpackage

// File: rtl/dh_encrypt_modexp_if.sv
// Request/result bundle of the encryption stage; master drives operands, slave answers.
// key_o exists only when DH_ENC_KEY_OUT_EN is defined.
interface dh_encrypt_modexp_if #(
  parameter int W  = 32,
  parameter int EW = 32
);
  logic          start;
  logic [W-1:0]  base;
  logic [EW-1:0] exp;
  logic [W-1:0]  mod;
  logic [W-1:0]  msg;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  cipher;
`ifdef DH_ENC_KEY_OUT_EN
  logic [W-1:0]  key_o;

  modport master (output start, base, exp, mod, msg,
                  input  busy, done, err, cipher, key_o);
  modport slave  (input  start, base, exp, mod, msg,
                  output busy, done, err, cipher, key_o);
`else
  modport master (output start, base, exp, mod, msg,
                  input  busy, done, err, cipher);
  modport slave  (input  start, base, exp, mod, msg,
                  output busy, done, err, cipher);
`endif
endinterface

// File: rtl/dh_encrypt_modexp_modmul.sv
// Bit-serial interleaved shift-add modular multiplier: r = a*b mod m, b < m required.
// Takes one load cycle plus W iterations; rdy is high during the last iteration.
module dh_modmul #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         rdy,
  output logic [W-1:0] r
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_q, a_d, b_q, b_d, m_q, m_d;
  logic [W+1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;
  logic [W+1:0]  m_ext, sum, sub1, sub2;

  always_comb begin
    m_ext = {2'b00, m_q};
    // acc < m keeps 2*acc + b below 3*m, so two subtractions always suffice
    sum   = (acc_q << 1) + (a_q[W-1] ? {2'b00, b_q} : '0);
    sub1  = (sum  >= m_ext) ? sum  - m_ext : sum;
    sub2  = (sub1 >= m_ext) ? sub1 - m_ext : sub1;

    a_d   = a_q;
    b_d   = b_q;
    m_d   = m_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    act_d = act_q;
    if (go) begin
      a_d   = a;
      b_d   = b;
      m_d   = m;
      acc_d = '0;
      cnt_d = CW'(W);
      act_d = 1'b1;
    end else if (act_q) begin
      acc_d = sub2;
      a_d   = a_q << 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) act_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      m_q   <= m_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  assign rdy = act_q && (cnt_q == CW'(1));
  assign r   = acc_q[W-1:0];

endmodule

// File: rtl/dh_encrypt_modexp.sv
// Encryption stage: k = base^exp mod mod by left-to-right square-and-multiply, cipher = k ^ msg.
// Define DH_ENC_KEY_OUT_EN to expose the registered key on key_o.
module dh_encrypt_modexp
  import dh_pkg::*;
#(
  parameter int W  = 32,
  parameter int EW = 32
) (
  input  logic clk,
  input  logic rst,
  dh_encrypt_modexp_if.slave bus
);
  localparam int IW = (EW > 1) ? $clog2(EW) : 1;

  dh_enc_state_t state_q, state_d;
  logic [W-1:0]  base_q, base_d, mod_q, mod_d, msg_q, msg_d;
  logic [W-1:0]  g_q, g_d, cipher_q, cipher_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          go_q, go_d, r_one_q, r_one_d;
`ifdef DH_ENC_KEY_OUT_EN
  logic [W-1:0]  key_q, key_d;
`endif

  logic          mm_rdy;
  logic [W-1:0]  mm_a, mm_b, mm_r, r_cur;

  // Running result is the constant 1 until the first square has been issued.
  assign r_cur = r_one_q ? W'(1) : mm_r;

  always_comb begin
    mm_a = r_cur;
    mm_b = r_cur;
    case (state_q)
      S_REDUCE: begin
        mm_a = base_q;
        mm_b = W'(1);
      end
      S_MUL:   mm_b = g_q;
      default: ;
    endcase
  end

  dh_modmul #(.W(W)) u_modmul (
    .clk (clk),
    .rst (rst),
    .go  (go_q),
    .a   (mm_a),
    .b   (mm_b),
    .m   (mod_q),
    .rdy (mm_rdy),
    .r   (mm_r)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    msg_d    = msg_q;
    g_d      = g_q;
    idx_d    = idx_q;
    cipher_d = cipher_q;
    busy_d   = busy_q;
    err_d    = err_q;
    r_one_d  = r_one_q;
    done_d   = 1'b0;
    go_d     = 1'b0;
`ifdef DH_ENC_KEY_OUT_EN
    key_d    = key_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          base_d  = bus.base;
          exp_d   = bus.exp;
          mod_d   = bus.mod;
          msg_d   = bus.msg;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mod_q < W'(2)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          r_one_d = 1'b1;
          idx_d   = IW'(EW - 1);
          go_d    = 1'b1;
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (mm_rdy) begin
          go_d    = 1'b1;
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        // The reduced base is still in the multiplier while the first square loads.
        if (go_q && r_one_q) begin
          g_d     = mm_r;
          r_one_d = 1'b0;
        end
        if (mm_rdy) begin
          if (exp_q[idx_q]) begin
            go_d    = 1'b1;
            state_d = S_MUL;
          end else if (idx_q == '0) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q - IW'(1);
            go_d    = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mm_rdy) begin
          if (idx_q == '0) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q - IW'(1);
            go_d    = 1'b1;
            state_d = S_SQR;
          end
        end
      end
      S_FIN: begin
        cipher_d = err_q ? '0 : (r_cur ^ msg_q);
`ifdef DH_ENC_KEY_OUT_EN
        key_d    = err_q ? '0 : r_cur;
`endif
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      msg_q    <= '0;
      g_q      <= '0;
      idx_q    <= '0;
      cipher_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      go_q     <= 1'b0;
      r_one_q  <= 1'b0;
`ifdef DH_ENC_KEY_OUT_EN
      key_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      msg_q    <= msg_d;
      g_q      <= g_d;
      idx_q    <= idx_d;
      cipher_q <= cipher_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      go_q     <= go_d;
      r_one_q  <= r_one_d;
`ifdef DH_ENC_KEY_OUT_EN
      key_q    <= key_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.cipher = cipher_q;
`ifdef DH_ENC_KEY_OUT_EN
  assign bus.key_o  = key_q;
`endif

endmodule

// File: tb/tb_dh_encrypt_modexp.sv
// Bench for dh_encrypt_modexp: directed cases plus random jobs against a plain-arithmetic
// modexp model; also checks done latency, busy window, ignored start and mid-job reset.
module tb_dh_encrypt_modexp;
  import dh_pkg::*;

  localparam int W  = 32;
  localparam int EW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dh_encrypt_modexp_if #(.W(W), .EW(EW)) bus ();

  dh_encrypt_modexp #(.W(W), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int last_edge = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, req);
    end
  endtask

  // Right-to-left binary exponentiation with 64-bit products.
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [EW-1:0] e,
                                           input logic [W-1:0] m);
    longint unsigned res, sq, mm;
    mm  = 64'(m);
    res = 1;
    sq  = 64'(b) % mm;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) res = (res * sq) % mm;
      sq = (sq * sq) % mm;
    end
    return W'(res);
  endfunction

  // Called at a negedge; drives start there so it is sampled at the next edge (edge 0).
  task automatic run_job(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m,
                         input logic [W-1:0] msg, input int poke_at, input bit idle_after,
                         input string tag);
    logic          err_exp;
    logic [W-1:0]  k_exp, c_exp;
    int            n_exp, k;
    bit            got, busy_bad;
    err_exp = (m < 2);
    k_exp   = err_exp ? '0 : ref_pow(b, e, m);
    c_exp   = err_exp ? '0 : (k_exp ^ msg);
    n_exp   = err_exp ? 3 : dh_latency(W, EW, $countones(e));

    bus.start = 1'b1;
    bus.base  = b;
    bus.exp   = e;
    bus.mod   = m;
    bus.msg   = msg;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.base  = $urandom;
    bus.exp   = $urandom;
    bus.mod   = $urandom;
    bus.msg   = $urandom;
    k = 1;
    got = 0;
    busy_bad = 0;
    while (k <= n_exp + 50) begin
      if (bus.busy !== 1'b1) busy_bad = 1;
      if (bus.done === 1'b1) begin
        got = 1;
        break;
      end
      if (k == poke_at) begin
        bus.start = 1'b1;
        bus.base  = $urandom;
        bus.exp   = $urandom;
        bus.mod   = $urandom | 32'h2;
        bus.msg   = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    last_edge = k;
    check_val({tag, "_done_seen"}, 64'(got), 64'd1);
    check_val({tag, "_done_edge"}, 64'(k), 64'(n_exp));
    check_val({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
    check_val({tag, "_cipher"}, 64'(bus.cipher), 64'(c_exp));
    check_val({tag, "_err"}, 64'(bus.err), 64'(err_exp));
`ifdef DH_ENC_KEY_OUT_EN
    check_val({tag, "_key"}, 64'(bus.key_o), 64'(k_exp));
`endif
    if (idle_after) begin
      @(posedge clk);
      @(negedge clk);
      check_val({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      check_val({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
      check_val({tag, "_cipher_held"}, 64'(bus.cipher), 64'(c_exp));
      check_val({tag, "_err_held"}, 64'(bus.err), 64'(err_exp));
    end
  endtask

  task automatic run_abort(input int abort_at);
    bit done_bad;
    bus.start = 1'b1;
    bus.base  = $urandom;
    bus.exp   = $urandom | 32'h8000_0000;
    bus.mod   = $urandom | 32'h8000_0000;
    bus.msg   = $urandom;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    done_bad = 0;
    for (int k = 1; k < abort_at; k++) begin
      if (bus.done === 1'b1) done_bad = 1;
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check_val("abort_busy", 64'(bus.busy), 64'd0);
    check_val("abort_err", 64'(bus.err), 64'd0);
    check_val("abort_cipher", 64'(bus.cipher), 64'd0);
`ifdef DH_ENC_KEY_OUT_EN
    check_val("abort_key", 64'(bus.key_o), 64'd0);
`endif
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_bad = 1;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_bad = 1;
    end
    check_val("abort_no_done", 64'(done_bad), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] msg_v, m_v;
    bus.start = 1'b0;
    bus.base  = '0;
    bus.exp   = '0;
    bus.mod   = '0;
    bus.msg   = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_err", 64'(bus.err), 64'd0);
    check_val("rst_cipher", 64'(bus.cipher), 64'd0);
`ifdef DH_ENC_KEY_OUT_EN
    check_val("rst_key", 64'(bus.key_o), 64'd0);
`endif

    run_job(32'd3, 32'd5, 32'd7, 32'hA, 0, 1'b1, "t_small");
    check_val("t_small_cipher_const", 64'(bus.cipher), 64'hF);
    check_val("t_small_edge_const", 64'(last_edge), 64'd1158);

    msg_v = $urandom;
    run_job(32'd100, 32'd2, 32'd13, msg_v, 0, 1'b1, "t_reduce");
    check_val("t_reduce_key_const", 64'(bus.cipher ^ msg_v), 64'd3);

    run_job(32'd2, 32'd32, 32'hFFFF_FFFB, 32'h0, 0, 1'b1, "t_fullw");
    check_val("t_fullw_cipher_const", 64'(bus.cipher), 64'd5);

    run_job($urandom, 32'd0, 32'd11, 32'h3, 0, 1'b1, "t_exp0");
    check_val("t_exp0_cipher_const", 64'(bus.cipher), 64'h2);

    run_job($urandom, $urandom, 32'd1, $urandom, 0, 1'b1, "t_mod1");
    check_val("t_mod1_edge_const", 64'(last_edge), 64'd3);
    run_job($urandom, $urandom, 32'd0, $urandom, 0, 1'b1, "t_mod0");

    run_job($urandom, $urandom, $urandom | 32'h2, $urandom, 100, 1'b0, "t_poke");
    run_job($urandom, $urandom, $urandom | 32'h2, $urandom, 0, 1'b1, "t_b2b");

    for (int j = 0; j < 6; j++) begin
      m_v = (j % 2 == 0) ? 32'($urandom_range(2, 60)) : ($urandom | 32'h8000_0000);
      run_job($urandom, $urandom, m_v, $urandom, 0, 1'b1, $sformatf("t_rand%0d", j));
    end

    run_abort(500);
    run_job($urandom, $urandom, $urandom | 32'h2, $urandom, 0, 1'b1, "t_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
